// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI address-channel arbiter.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

package axi_arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam int unsigned MAX_TAG_BITS = 8;

    // One-hot master tag; callers trim to their own TAG_BITS.
    function automatic logic [MAX_TAG_BITS-1:0] onehot_tag(input int unsigned idx);
        onehot_tag = MAX_TAG_BITS'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_grant_picker.sv
// Combinational picker: fixed (highest index) or round-robin from a start pointer.
module rr_grant_picker
    import axi_arb_pkg::*;
#(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    input  arb_mode_e     mode,
    output logic [IW-1:0] grant,
    output logic          any_req
);

    // RR: lowest requester at/after start wins, otherwise lowest one below start.
    always_comb begin
        grant   = '0;
        any_req = |req;
        if (mode == ARB_FIXED) begin
            for (int i = 0; i < int'(N); i++) begin
                if (req[i]) grant = IW'(i);
            end
        end else begin
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (req[i] && (i < int'(start))) grant = IW'(i);
            end
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (req[i] && (i >= int'(start))) grant = IW'(i);
            end
        end
    end

endmodule

// File: rtl/axi_addr_arbiter_rr.sv
// N-master arbiter for one AXI address channel; grant is held until handshake
// and the forwarded ID is tagged with the one-hot index of the winning master.
module axi_addr_arbiter_rr
    import axi_arb_pkg::*;
#(
    parameter  int unsigned N_MASTERS = 2,
    parameter  int unsigned TAG_BITS  = 4,
    parameter  arb_mode_e   ARB_MODE  = ARB_FIXED,
    parameter  int unsigned ID_BITS   = `AXI_ID_BITS,
    parameter  int unsigned ADDR_BITS = `AXI_ADDR_BITS,
    parameter  int unsigned LEN_BITS  = `AXI_LEN_BITS,
    parameter  int unsigned SIZE_BITS = `AXI_SIZE_BITS,
    localparam int unsigned IDX_BITS  = $clog2(N_MASTERS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_MASTERS-1:0][ID_BITS-1:0]    ID_M,
    input  logic [N_MASTERS-1:0][ADDR_BITS-1:0]  ADDR_M,
    input  logic [N_MASTERS-1:0][LEN_BITS-1:0]   LEN_M,
    input  logic [N_MASTERS-1:0][SIZE_BITS-1:0]  SIZE_M,
    input  logic [N_MASTERS-1:0][1:0]            BURST_M,
    input  logic [N_MASTERS-1:0]                 VALID_M,
    output logic [N_MASTERS-1:0]                 READY_M,
    output logic [TAG_BITS+ID_BITS-1:0]          IDS_S,
    output logic [ADDR_BITS-1:0]                 ADDR_S,
    output logic [LEN_BITS-1:0]                  LEN_S,
    output logic [SIZE_BITS-1:0]                 SIZE_S,
    output logic [1:0]                           BURST_S,
    output logic                                 VALID_S,
    input  logic                                 READY_S,
    output logic [IDX_BITS-1:0]                  GNT_IDX
);

    logic                lock;
    logic [IDX_BITS-1:0] lock_idx;
    logic [IDX_BITS-1:0] rr_ptr;
    logic [IDX_BITS-1:0] pick_idx;
    logic [IDX_BITS-1:0] grant;
    logic                any_req;
    logic                active;
    logic                valid_s_c;
    logic                hs_c;

    rr_grant_picker #(
        .N       (N_MASTERS)
    ) u_picker (
        .req     (VALID_M),
        .start   (rr_ptr),
        .mode    (ARB_MODE),
        .grant   (pick_idx),
        .any_req (any_req)
    );

    // A waiting master keeps the grant so its address beat never changes mid-wait.
    assign grant     = lock ? lock_idx : pick_idx;
    assign active    = rst & (lock | any_req);
    assign valid_s_c = rst & VALID_M[grant];
    assign hs_c      = valid_s_c & READY_S;

    always_comb begin
        IDS_S   = '0;
        ADDR_S  = '0;
        LEN_S   = '0;
        SIZE_S  = '0;
        BURST_S = '0;
        GNT_IDX = '0;
        READY_M = '0;
        VALID_S = valid_s_c;
        if (active) begin
            IDS_S          = {TAG_BITS'(onehot_tag(32'(grant))), ID_M[grant]};
            ADDR_S         = ADDR_M[grant];
            LEN_S          = LEN_M[grant];
            SIZE_S         = SIZE_M[grant];
            BURST_S        = BURST_M[grant];
            GNT_IDX        = grant;
            READY_M[grant] = VALID_M[grant] & READY_S;
        end
    end

    // Lock follows a stalled beat; a handshake or a dropped VALID releases it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock     <= 1'b0;
            lock_idx <= '0;
            rr_ptr   <= '0;
        end else begin
            lock <= valid_s_c & ~READY_S;
            if (valid_s_c && !READY_S) begin
                lock_idx <= grant;
            end
            if ((ARB_MODE == ARB_RR) && hs_c) begin
                rr_ptr <= (32'(grant) == N_MASTERS - 1) ? '0 : grant + IDX_BITS'(1);
            end
        end
    end

`ifndef SYNTHESIS
    lock_hold_a : assert property (@(posedge clk) disable iff (!rst) lock |-> VALID_M[lock_idx])
        else $warning("locked master %0d dropped VALID before its handshake", lock_idx);
`endif

endmodule
